target_spawn_scheduler: RTL and testbench



---
 rtl/target_pkg.sv | 19 +
 rtl/spawn_interval_timer.sv | 33 +++
 rtl/target_spawn_scheduler.sv | 136 +++++++++++++
 tb/tb_target_spawn_scheduler.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/target_pkg.sv
// Shared encodings and helpers for the target spawn scheduler.
// The LFSR constants are used only when TARGET_SPAWN_LFSR_EN is defined.
package target_pkg;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_COUNT  = 2'd1;
   localparam logic [1:0] S_SEARCH = 2'd2;
   localparam logic [1:0] S_SPAWN  = 2'd3;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Bits needed to hold the value n (at least one bit).
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/spawn_interval_timer.sv
// Spawn interval counter: synchronous clear, counts while enabled and
// saturates at PERIOD-1, where done stays high until the next clear.
module spawn_interval_timer #(
   parameter int PERIOD = 25000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic done_o
);

   localparam int W = $clog2(PERIOD);
   localparam logic [W-1:0] TERM = W'(PERIOD - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign done_o = (cnt_q == TERM);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !done_o)
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/target_spawn_scheduler.sv
// Round-robin spawn scheduler for NUM_TARGETS target slots, gated by MAX_ACTIVE.
// Define TARGET_SPAWN_LFSR_EN to randomize the scan start slot with a 16-bit LFSR.
module target_spawn_scheduler
   import target_pkg::*;
#(
   parameter int NUM_TARGETS  = 4,
   parameter int SPAWN_PERIOD = 25000000,
   parameter int MAX_ACTIVE   = 3,
   parameter int CNT_W        = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 titleoff,
   input  logic                                 over,
   input  logic [NUM_TARGETS-1:0]               slot_clear,
   output logic [NUM_TARGETS-1:0]               spawn,
   output logic [cnt_width(NUM_TARGETS)-1:0]    active_count,
   output logic [CNT_W-1:0]                     spawn_total,
   output logic                                 busy
);

   localparam int PW = $clog2(NUM_TARGETS);
   localparam int AW = cnt_width(NUM_TARGETS);
   localparam logic [PW-1:0] PTR_LAST  = PW'(NUM_TARGETS - 1);
   localparam logic [AW-1:0] SCAN_LAST = AW'(NUM_TARGETS - 1);
   localparam logic [AW-1:0] MAX_A     = AW'(MAX_ACTIVE);

   logic [1:0]             state_q, state_d;
   logic [PW-1:0]          ptr_q, ptr_d, ptr_inc;
   logic [AW-1:0]          scan_q, scan_d;
   logic [AW-1:0]          active_q, active_d, occ;
   logic [CNT_W-1:0]       total_q, total_d;
   logic [NUM_TARGETS-1:0] spawn_q, spawn_d;
   logic                   abort, tmr_clr, tmr_done;
   logic [PW-1:0]          start_ptr;

   assign abort   = !titleoff || over;
   assign tmr_clr = abort || (state_q == S_IDLE) || (state_q == S_SPAWN);
   assign ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);

   spawn_interval_timer #(.PERIOD(SPAWN_PERIOD)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (tmr_clr),
      .en_i   (state_q == S_COUNT),
      .done_o (tmr_done)
   );

`ifdef TARGET_SPAWN_LFSR_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   assign start_ptr = PW'(lfsr_q % 16'(NUM_TARGETS));
`else
   assign start_ptr = ptr_q;
`endif

   always_comb begin
      occ = '0;
      for (int i = 0; i < NUM_TARGETS; i++)
         occ = occ + AW'(!slot_clear[i]);
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      scan_d  = scan_q;
      total_d = total_q;
      if (abort) begin
         state_d = S_IDLE;
         ptr_d   = '0;
         scan_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_COUNT;
               total_d = '0;
            end
            S_COUNT: begin
               if (tmr_done && (active_q < MAX_A)) begin
                  state_d = S_SEARCH;
                  scan_d  = '0;
                  ptr_d   = start_ptr;
               end
            end
            S_SEARCH: begin
               // ptr is left in place on a hit so it doubles as the selected slot
               if (slot_clear[ptr_q]) begin
                  state_d = S_SPAWN;
               end else begin
                  ptr_d  = ptr_inc;
                  scan_d = scan_q + AW'(1);
                  if (scan_q == SCAN_LAST) state_d = S_COUNT;
               end
            end
            S_SPAWN: begin
               ptr_d   = ptr_inc;
               state_d = S_COUNT;
               if (total_q != '1) total_d = total_q + CNT_W'(1);
            end
            default: state_d = S_IDLE;
         endcase
      end
      active_d = (state_d == S_IDLE) ? '0 : occ;
      spawn_d  = '0;
      if (state_d == S_SPAWN) spawn_d[ptr_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         scan_q   <= '0;
         active_q <= '0;
         total_q  <= '0;
         spawn_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         scan_q   <= scan_d;
         active_q <= active_d;
         total_q  <= total_d;
         spawn_q  <= spawn_d;
      end
   end

   assign spawn        = spawn_q;
   assign active_count = active_q;
   assign spawn_total  = total_q;
   assign busy         = (state_q == S_SEARCH) || (state_q == S_SPAWN);

endmodule

// File: tb/tb_target_spawn_scheduler.sv
// Bench for target_spawn_scheduler: directed vector table plus randomized run
// against a behavioural model (N=4, period 8, max active 3, 2-bit spawn total).
module tb_target_spawn_scheduler;

   localparam int N     = 4;
   localparam int P     = 8;
   localparam int MAXA  = 3;
   localparam int CW    = 2;
   localparam int TOTMX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          toff = 1'b0;
   logic          ovr = 1'b0;
   logic [N-1:0]  sc = '1;
   logic [N-1:0]  spawn;
   logic [2:0]    active_count;
   logic [CW-1:0] spawn_total;
   logic          busy;

   int checks = 0;
   int failures = 0;

   target_spawn_scheduler #(
      .NUM_TARGETS(N), .SPAWN_PERIOD(P), .MAX_ACTIVE(MAXA), .CNT_W(CW)
   ) dut (
      .clk          (clk),
      .reset        (rst),
      .titleoff     (toff),
      .over         (ovr),
      .slot_clear   (sc),
      .spawn        (spawn),
      .active_count (active_count),
      .spawn_total  (spawn_total),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Behavioural model: a running flag, an interval count, an optional scan in
   // progress, and the slot currently being fired (-1 = none).
   bit m_run = 0;
   bit m_scanning = 0;
   int m_cnt = 0;
   int m_fire = -1;
   int m_ptr = 0;
   int m_scan = 0;
   int m_total = 0;
   int m_active = 0;

   task automatic model_step();
      int pop;
      int act_old;
      pop = 0;
      for (int i = 0; i < N; i++) if (!sc[i]) pop++;
      if (rst) begin
         m_run = 0; m_scanning = 0; m_cnt = 0; m_fire = -1;
         m_ptr = 0; m_scan = 0; m_total = 0; m_active = 0;
      end else if (!toff || ovr) begin
         m_run = 0; m_scanning = 0; m_cnt = 0; m_fire = -1;
         m_ptr = 0; m_scan = 0; m_active = 0;
      end else if (!m_run) begin
         m_run = 1; m_cnt = 0; m_total = 0; m_active = pop;
      end else begin
         act_old = m_active;
         m_active = pop;
         if (m_fire >= 0) begin
            m_ptr = (m_fire + 1) % N;
            if (m_total < TOTMX) m_total++;
            m_cnt = 0;
            m_fire = -1;
         end else if (m_scanning) begin
            if (sc[m_ptr]) begin
               m_fire = m_ptr;
               m_scanning = 0;
            end else begin
               m_ptr = (m_ptr + 1) % N;
               m_scan++;
               if (m_scan == N) m_scanning = 0;
            end
         end else if (m_cnt == P - 1) begin
            if (act_old < MAXA) begin
               m_scanning = 1;
               m_scan = 0;
            end
         end else begin
            m_cnt++;
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      logic [N-1:0] esp;
      @(posedge clk);
      model_step();
      #1;
      esp = (m_fire >= 0) ? N'(1 << m_fire) : '0;
      chk("model.spawn", 32'(spawn), 32'(esp));
      chk("model.active", 32'(active_count), 32'(m_active));
      chk("model.total", 32'(spawn_total), 32'(m_total));
      chk("model.busy", 32'(busy), 32'(m_scanning || (m_fire >= 0)));
   endtask

   typedef struct {
      logic         rst, toff, ovr;
      logic [N-1:0] sc;
      int           n;
      logic [N-1:0] esp;
      int           eact, etot;
      logic         ebusy;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic r, t, o, input logic [N-1:0] s, input int n,
                      input logic [N-1:0] esp, input int eact, etot, input logic eb);
      vec_t v;
      v.rst = r; v.toff = t; v.ovr = o; v.sc = s; v.n = n;
      v.esp = esp; v.eact = eact; v.etot = etot; v.ebusy = eb;
      tv.push_back(v);
   endtask

   initial begin
      // inputs held for n cycles, outputs checked after the last one
      add(1, 0, 0, 4'b1111,  2, 4'b0000, 0, 0, 0); // reset state
      add(0, 1, 0, 4'b1111,  9, 4'b0000, 0, 0, 1); // searching after terminal
      add(0, 1, 0, 4'b1111,  1, 4'b0001, 0, 0, 1); // 9 cycles after count entry
      add(0, 1, 0, 4'b1111,  1, 4'b0000, 0, 1, 0);
      add(0, 1, 0, 4'b1111,  9, 4'b0010, 0, 1, 1); // 10-cycle spacing
      add(0, 1, 0, 4'b1111, 10, 4'b0100, 0, 2, 1);
      add(0, 1, 0, 4'b1111, 10, 4'b1000, 0, 3, 1);
      add(0, 1, 0, 4'b1111, 10, 4'b0001, 0, 3, 1); // wraps round
      add(0, 1, 0, 4'b1111,  1, 4'b0000, 0, 3, 0); // total saturated at 3
      add(0, 1, 0, 4'b1111,  9, 4'b0010, 0, 3, 1); // ptr now 2
      add(0, 1, 0, 4'b1011, 10, 4'b0000, 1, 3, 1); // slot 2 skipped
      add(0, 1, 0, 4'b1011,  1, 4'b1000, 1, 3, 1); // one cycle later
      add(0, 1, 0, 4'b1000,  1, 4'b0000, 3, 3, 0); // three active
      add(0, 1, 0, 4'b1000, 20, 4'b0000, 3, 3, 0); // held at cap
      add(0, 1, 0, 4'b1010,  1, 4'b0000, 2, 3, 0); // registered update
      add(0, 1, 0, 4'b1010,  2, 4'b0000, 2, 3, 1); // slot 0 skipped
      add(0, 1, 0, 4'b1010,  1, 4'b0010, 2, 3, 1);
      add(0, 1, 0, 4'b1111,  9, 4'b0000, 0, 3, 1); // about to spawn
      add(0, 1, 1, 4'b1111,  1, 4'b0000, 0, 3, 0); // over wins
      add(0, 1, 0, 4'b1101,  1, 4'b0000, 1, 0, 0); // total cleared on entry
      add(0, 1, 0, 4'b1110,  8, 4'b0000, 1, 0, 1); // mid-search
      add(1, 1, 0, 4'b1110,  1, 4'b0000, 0, 0, 0); // reset mid-search
      add(0, 1, 0, 4'b1111, 10, 4'b0001, 0, 0, 1); // ptr restarted at 0

      for (int k = 0; k < tv.size(); k++) begin
         rst = tv[k].rst; toff = tv[k].toff; ovr = tv[k].ovr; sc = tv[k].sc;
         repeat (tv[k].n) tick();
         chk($sformatf("vec%0d.spawn", k), 32'(spawn), 32'(tv[k].esp));
         chk($sformatf("vec%0d.active", k), 32'(active_count), 32'(tv[k].eact));
         chk($sformatf("vec%0d.total", k), 32'(spawn_total), 32'(tv[k].etot));
         chk($sformatf("vec%0d.busy", k), 32'(busy), 32'(tv[k].ebusy));
      end

      for (int c = 0; c < 4000; c++) begin
         rst  = ($urandom_range(0, 999) == 0);
         toff = ($urandom_range(0, 199) != 0);
         ovr  = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 5) == 0) sc = N'($urandom | $urandom);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
